// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one imem request
// outstanding, and hands {pc, inst} to decode through an output slot plus a skid entry.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int unsigned XLEN = 32;

    // FULL is the only state in which the skid entry is occupied.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        FULL  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   skid_inst_q, skid_inst_d;

    logic              consume;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_inc;

    assign consume = valid_q && !stall_i;
    assign target  = redirect_pc_i & ~XLEN'(3);
    assign pc_inc  = fetch_pc_q + XLEN'(4);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            inst_q      <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    // Next-state, PC sequencing, slot/skid movement and redirect squash.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid_i) begin
                    fetch_pc_d = target;
                    addr_d     = target;
                end
            end
            FETCH: begin
                if (redirect_valid_i) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                    if (imem_ack_i) begin
                        addr_d = target;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = pc_inc;
                    addr_d     = pc_inc;
                    if (!valid_q || consume) begin
                        valid_d = 1'b1;
                        pc_d    = addr_q;
                        inst_d  = imem_rdata_i;
                    end else begin
                        skid_pc_d   = addr_q;
                        skid_inst_d = imem_rdata_i;
                        state_d     = FULL;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            DROP: begin
                // Old-path address stays on the bus until its response retires.
                if (redirect_valid_i) begin
                    fetch_pc_d = target;
                end
                if (imem_ack_i) begin
                    addr_d  = redirect_valid_i ? target : fetch_pc_q;
                    state_d = FETCH;
                end
            end
            FULL: begin
                if (redirect_valid_i) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                    addr_d     = target;
                    state_d    = FETCH;
                end else if (consume) begin
                    pc_d    = skid_pc_q;
                    inst_d  = skid_inst_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == FETCH) || (state_d == DROP);
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign if_valid_o  = valid_q;
    assign if_pc_o     = pc_q;
    assign if_inst_o   = inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall/skid, redirects, PC wrap, reset in DROP.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        ack_en, late_ack;

    logic        imem_req, imem_ack, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;

    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_inst;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory responder: combinational ack gated by bench controls, rdata tagged by address.
    assign imem_ack   = ack_en && (imem_req || late_ack);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign w_ack      = w_req;
    assign w_rdata    = w_addr ^ 32'hA5A5_0000;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .resetn(resetn),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .stall_i(stall), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .resetn(resetn),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(w_ack), .imem_rdata_i(w_rdata),
        .stall_i(w_zero), .redirect_valid_i(w_zero), .redirect_pc_i(w_zero32),
        .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the whole decode-facing slot at once.
    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(if_valid), 32'(v));
        if (v) begin
            chk({tag, ".pc"}, if_pc, pc);
            chk({tag, ".inst"}, if_inst, pc ^ 32'hA5A5_0000);
        end
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ack_en = 1'b1; late_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.pc", if_pc, 32'h0);
        chk("rst.inst", if_inst, 32'h0);
        chk("rst.waddr", w_addr, 32'hFFFF_FFF8);
        resetn = 1'b1;

        // Streaming, first if_valid two edges after release
        step();
        chk("e1.req", 32'(imem_req), 32'd1);
        chk("e1.addr", imem_addr, 32'h0);
        chk("e1.valid", 32'(if_valid), 32'd0);
        step();
        chk_slot("e2", 1'b1, 32'h0);
        chk("e2.addr", imem_addr, 32'h4);
        chk("wrap0", w_pc, 32'hFFFF_FFF8);
        step();
        chk_slot("e3", 1'b1, 32'h4);
        chk("wrap1", w_pc, 32'hFFFF_FFFC);
        step();
        chk_slot("e4", 1'b1, 32'h8);
        chk("wrap2", w_pc, 32'h0000_0000);

        // Stall for three cycles: 0xC lands in skid, requests stop
        stall = 1'b1;
        step();
        chk_slot("st1", 1'b1, 32'h8);
        chk("st1.req", 32'(imem_req), 32'd0);
        chk("st1.addr", imem_addr, 32'h10);
        chk("wrap3", w_pc, 32'h0000_0004);
        chk("wrap3.v", 32'(w_valid), 32'd1);
        step();
        chk_slot("st2", 1'b1, 32'h8);
        chk("st2.req", 32'(imem_req), 32'd0);
        step();
        chk_slot("st3", 1'b1, 32'h8);
        stall = 1'b0;
        step();
        chk_slot("rel1", 1'b1, 32'hC);
        chk("rel1.req", 32'(imem_req), 32'd1);
        step();
        chk_slot("rel2", 1'b1, 32'h10);

        // Run up to an outstanding request at 0x20, then redirect with ack held off
        step(); step(); step();
        chk_slot("pre3", 1'b1, 32'h1C);
        chk("pre3.addr", imem_addr, 32'h20);
        ack_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0; redirect_pc = '0;
        chk("drop1.valid", 32'(if_valid), 32'd0);
        chk("drop1.addr", imem_addr, 32'h20);
        chk("drop1.req", 32'(imem_req), 32'd1);
        step();
        chk("drop2.addr", imem_addr, 32'h20);
        step();
        chk("drop3.addr", imem_addr, 32'h20);
        chk("drop3.valid", 32'(if_valid), 32'd0);
        ack_en = 1'b1;
        step();
        chk("drop4.addr", imem_addr, 32'h100);
        chk("drop4.valid", 32'(if_valid), 32'd0);
        step();
        chk_slot("rd1", 1'b1, 32'h100);

        // Fill skid under stall, then redirect from FULL with stall still high
        stall = 1'b1;
        step();
        chk_slot("full", 1'b1, 32'h100);
        chk("full.req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("rf.valid", 32'(if_valid), 32'd0);
        chk("rf.addr", imem_addr, 32'h40);
        step();
        chk_slot("rf1", 1'b1, 32'h40);

        // Redirect coincident with ack and stall; low target bits forced to zero
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("ra.valid", 32'(if_valid), 32'd0);
        chk("ra.addr", imem_addr, 32'h200);
        step();
        chk_slot("ra1", 1'b1, 32'h200);

        // Reset while in DROP; a late ack during IDLE must not load anything
        ack_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("rd.req", 32'(imem_req), 32'd1);
        chk("rd.addr", imem_addr, 32'h204);
        resetn = 1'b0;
        step();
        chk("rr.req", 32'(imem_req), 32'd0);
        chk("rr.valid", 32'(if_valid), 32'd0);
        chk("rr.addr", imem_addr, 32'h0);
        resetn = 1'b1; ack_en = 1'b1; late_ack = 1'b1;
        step();
        late_ack = 1'b0;
        chk("ri.valid", 32'(if_valid), 32'd0);
        chk("ri.addr", imem_addr, 32'h0);
        chk("ri.req", 32'(imem_req), 32'd1);
        step();
        chk_slot("ri1", 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
